gpio_loopback_injector: RTL

- Sits directly downstream of the AHB GPIO block's GPIOOUT and drives its GPIOIN; closes the GPIO loop for the unit bench and system tests.
- Delays the 17-bit word (16 data bits plus MSB parity) by a programmable number of cycles.
- On request, corrupts the word for a bounded window so that the GPIO block's parity checker can be exercised.
- Also injects error patterns that parity cannot detect, and counts every injection event.

---
 rtl/gpio_loopback_injector.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gpio_loopback_injector.sv
// GPIO loopback with programmable latency and parity-fault injection.
// Corrupts GPIOOUT for a bounded window on an error_i rising edge and counts accepted/dropped requests.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for an error_i rising edge
// S_INJECT  | mask applied at the pipeline input, PULSE_LEN cycles
// S_HOLDOFF | no mask, new requests dropped for HOLDOFF cycles
module gpio_loopback_injector #(
   parameter int DATA_WIDTH = 16,
   parameter int LATENCY    = 2,
   parameter int PULSE_LEN  = 4,
   parameter int HOLDOFF    = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  error_i,
   input  logic [1:0]            err_mode_i,
   input  logic [4:0]            err_bit_i,
   input  logic [DATA_WIDTH:0]   GPIOOUT_i,
   output logic [DATA_WIDTH:0]   GPIOIN_o,
   output logic                  inj_active_o,
   output logic                  busy_o,
   output logic [15:0]           inj_count_o,
   output logic [7:0]            drop_count_o
);

   localparam int IW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_INJECT  = 2'd1,
      S_HOLDOFF = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [1:0]          mode_q, mode_d;
   logic [IW-1:0]       bit_q, bit_d;
   logic [IW-1:0]       bit_nxt;
   logic                error_q;
   logic                rise;
   logic                accept;
   logic                drop;
   logic [DATA_WIDTH:0] mask;

   logic [DATA_WIDTH:0] pipe_data [LATENCY];
   logic                pipe_inj  [LATENCY];

   assign rise   = error_i & ~error_q;
   assign busy_o = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         mode_q       <= '0;
         bit_q        <= '0;
         error_q      <= 1'b0;
         inj_count_o  <= '0;
         drop_count_o <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         bit_q   <= bit_d;
         error_q <= error_i;
         if (accept && (inj_count_o != 16'hFFFF))
            inj_count_o <= inj_count_o + 16'd1;
         if (drop && (drop_count_o != 8'hFF))
            drop_count_o <= drop_count_o + 8'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      bit_d   = bit_q;
      accept  = 1'b0;
      drop    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise) begin
               accept  = 1'b1;
               mode_d  = err_mode_i;
               bit_d   = IW'(32'(err_bit_i) % DATA_WIDTH);
               cnt_d   = 8'(PULSE_LEN);
               state_d = S_INJECT;
            end
         end
         S_INJECT: begin
            drop = rise;
            if (cnt_q == 8'd1) begin
               if (HOLDOFF > 0) begin
                  state_d = S_HOLDOFF;
                  cnt_d   = 8'(HOLDOFF);
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_HOLDOFF: begin
            drop = rise;
            if (cnt_q == 8'd1)
               state_d = S_IDLE;
            else
               cnt_d = cnt_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // modes 2 and 3 flip two bits so parity stays consistent
   always_comb begin
      bit_nxt = IW'((32'(bit_q) + 32'd1) % DATA_WIDTH);
      mask    = '0;
      if (state_q == S_INJECT) begin
         case (mode_q)
            2'd0: mask[DATA_WIDTH] = 1'b1;
            2'd1: mask[bit_q]      = 1'b1;
            2'd2: begin
               mask[bit_q]      = 1'b1;
               mask[DATA_WIDTH] = 1'b1;
            end
            default: begin
               mask[bit_q]   = 1'b1;
               mask[bit_nxt] = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_data[i] <= '0;
            pipe_inj[i]  <= 1'b0;
         end
      end else begin
         pipe_data[0] <= GPIOOUT_i ^ mask;
         pipe_inj[0]  <= (state_q == S_INJECT);
         for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_inj[i]  <= pipe_inj[i-1];
         end
      end
   end

   assign GPIOIN_o     = pipe_data[LATENCY-1];
   assign inj_active_o = pipe_inj[LATENCY-1];

endmodule
